// File: rtl/newhope_pkg.sv
// Constants shared by the NewHope decryption controller and the encrypter:
// sequencer phase codes, poly_arithmetic opcodes and packed polynomial sizes.
package newhope_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OP_W    = 2;

    typedef enum logic [PHASE_W-1:0] {
        HOLD       = 3'd0,
        UNPACK_1   = 3'd1,
        UNPACK_2   = 3'd2,
        MULT       = 3'd3,
        INV_NTT    = 3'd4,
        GAMMA_MULT = 3'd5,
        SUB        = 3'd6,
        DECODE     = 3'd7
    } phase_e;

    localparam logic [OP_W-1:0] OP_MULT         = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB          = 2'd2;
    localparam logic [OP_W-1:0] OP_MULT_PRECOMP = 2'd3;

    // Packed 14-bit polynomial size in bytes
    function automatic int unsigned pk_bytes(input int unsigned n);
        return (7 * n) / 4;
    endfunction

    // Compressed (3-bit) v size in bytes
    function automatic int unsigned v_bytes(input int unsigned n);
        return (3 * n) / 8;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags the TIMEOUT-th cycle spent in one phase.
module phase_watchdog #(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned TW      = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The first cycle in a phase sees count 0, so this is cycle number TIMEOUT
    assign expired_c = en_i && (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/decrypt_sequencer.sv
// Control sequencer for the NewHope CPA decryption datapath: steps the
// unpack / multiply / inverse-NTT / subtract / decode phases with one queued request.
module decrypt_sequencer
    import newhope_pkg::*;
#(
    parameter int unsigned N        = 512,
    parameter int unsigned PK_BYTES = pk_bytes(N),
    parameter int unsigned V_BYTES  = v_bytes(N),
    parameter int unsigned IR_AW    = 11,
    parameter int unsigned TIMEOUT  = 65535,
    parameter int unsigned TW       = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 done_pd,
    input  logic                 done_decomp,
    input  logic                 done_pa,
    input  logic                 done_ntt,
    input  logic                 done_dec,
    output logic                 start_pd,
    output logic                 start_decomp,
    output logic                 start_pa,
    output logic                 start_ntt,
    output logic                 start_dec,
    output logic [OP_W-1:0]      op_code_pa,
    output logic [PHASE_W-1:0]   phase,
    output logic [IR_AW-1:0]     ir_base_a,
    output logic [IR_AW-1:0]     ir_base_b,
    output logic                 busy,
    output logic                 pending,
    output logic                 done,
    output logic                 error,
    output logic [PHASE_W-1:0]   err_phase
);

    phase_e          phase_q, phase_d;
    phase_e          err_phase_q, err_phase_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            start_pd_q, start_pd_d, start_decomp_q, start_decomp_d;
    logic            start_pa_q, start_pa_d, start_ntt_q, start_ntt_d;
    logic            start_dec_q, start_dec_d;
    logic            done_q, done_d, error_q, error_d, pending_q, pending_d;
    logic            pd_ok_q, pd_ok_d, dc_ok_q, dc_ok_d;
    logic            exit_c, wd_clr_c, wd_expired_c;

    phase_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr_c),
        .en_i      (phase_q != HOLD),
        .expired_c (wd_expired_c)
    );

    // Exit condition of the current phase; UNPACK_2 joins both unpack units
    always_comb begin
        exit_c = 1'b0;
        case (phase_q)
            UNPACK_1:              exit_c = done_pd;
            UNPACK_2:              exit_c = (pd_ok_q || done_pd) && (dc_ok_q || done_decomp);
            MULT, GAMMA_MULT, SUB: exit_c = done_pa;
            INV_NTT:               exit_c = done_ntt;
            DECODE:                exit_c = done_dec;
            default:               exit_c = 1'b0;
        endcase
    end

    always_comb begin
        phase_d        = phase_q;
        err_phase_d    = err_phase_q;
        op_d           = OP_MULT;
        start_pd_d     = 1'b0;
        start_decomp_d = 1'b0;
        start_pa_d     = 1'b0;
        start_ntt_d    = 1'b0;
        start_dec_d    = 1'b0;
        done_d         = 1'b0;
        error_d        = 1'b0;
        pending_d      = pending_q;
        pd_ok_d        = pd_ok_q;
        dc_ok_d        = dc_ok_q;

        if (abort) begin
            phase_d   = HOLD;
            pending_d = 1'b0;
            pd_ok_d   = 1'b0;
            dc_ok_d   = 1'b0;
        end else if (phase_q == HOLD) begin
            if (start || pending_q) begin
                phase_d        = UNPACK_1;
                start_pd_d     = 1'b1;
                start_decomp_d = 1'b1;
                pending_d      = 1'b0;
                err_phase_d    = HOLD;
                pd_ok_d        = 1'b0;
                dc_ok_d        = 1'b0;
            end
        end else begin
            if (start) pending_d = 1'b1;
            if (done_decomp) dc_ok_d = 1'b1;
            if (phase_q == UNPACK_2 && done_pd) pd_ok_d = 1'b1;

            if (exit_c) begin
                case (phase_q)
                    UNPACK_1:   begin phase_d = UNPACK_2;   start_pd_d  = 1'b1; end
                    UNPACK_2:   begin
                        phase_d    = MULT;
                        start_pa_d = 1'b1;
                        pd_ok_d    = 1'b0;
                        dc_ok_d    = 1'b0;
                    end
                    MULT:       begin phase_d = INV_NTT;    start_ntt_d = 1'b1; end
                    INV_NTT:    begin phase_d = GAMMA_MULT; start_pa_d  = 1'b1; end
                    GAMMA_MULT: begin phase_d = SUB;        start_pa_d  = 1'b1; end
                    SUB:        begin phase_d = DECODE;     start_dec_d = 1'b1; end
                    DECODE:     begin phase_d = HOLD;       done_d      = 1'b1; end
                    default:    phase_d = HOLD;
                endcase
            end else if (wd_expired_c) begin
                phase_d     = HOLD;
                error_d     = 1'b1;
                err_phase_d = phase_q;
            end
        end

        // Opcode follows the phase being entered, so it is valid with the start pulse
        case (phase_d)
            GAMMA_MULT: op_d = OP_MULT_PRECOMP;
            SUB:        op_d = OP_SUB;
            default:    op_d = OP_MULT;
        endcase
    end

    assign wd_clr_c = abort || (phase_d != phase_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q        <= HOLD;
            err_phase_q    <= HOLD;
            op_q           <= OP_MULT;
            start_pd_q     <= 1'b0;
            start_decomp_q <= 1'b0;
            start_pa_q     <= 1'b0;
            start_ntt_q    <= 1'b0;
            start_dec_q    <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            pending_q      <= 1'b0;
            pd_ok_q        <= 1'b0;
            dc_ok_q        <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            err_phase_q    <= err_phase_d;
            op_q           <= op_d;
            start_pd_q     <= start_pd_d;
            start_decomp_q <= start_decomp_d;
            start_pa_q     <= start_pa_d;
            start_ntt_q    <= start_ntt_d;
            start_dec_q    <= start_dec_d;
            done_q         <= done_d;
            error_q        <= error_d;
            pending_q      <= pending_d;
            pd_ok_q        <= pd_ok_d;
            dc_ok_q        <= dc_ok_d;
        end
    end

    assign start_pd     = start_pd_q;
    assign start_decomp = start_decomp_q;
    assign start_pa     = start_pa_q;
    assign start_ntt    = start_ntt_q;
    assign start_dec    = start_dec_q;
    assign op_code_pa   = op_q;
    assign phase        = phase_q;
    assign err_phase    = err_phase_q;
    assign done         = done_q;
    assign error        = error_q;
    assign pending      = pending_q;
    assign busy         = (phase_q != HOLD);
    assign ir_base_a    = (phase_q == UNPACK_2) ? IR_AW'(PK_BYTES + V_BYTES) : '0;
    assign ir_base_b    = IR_AW'(PK_BYTES);

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Bench for decrypt_sequencer: N=512 and N=1024 instances share stimulus and are
// checked each cycle against a phase-table reference model.
module tb_decrypt_sequencer;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [4:0]  dn;   // {dec, ntt, pa, decomp, pd}

    logic        st_pd, st_dc, st_pa, st_ntt, st_dec, busy, pend, done_o, err_o;
    logic [1:0]  op;
    logic [2:0]  ph, errph;
    logic [10:0] base_a, base_b;

    logic        st_pd2, st_dc2, st_pa2, st_ntt2, st_dec2, busy2, pend2, done2, err2;
    logic [1:0]  op2;
    logic [2:0]  ph2, errph2;
    logic [11:0] base_a2, base_b2;

    decrypt_sequencer #(.N(512), .IR_AW(11), .TIMEOUT(TO), .TW(17)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .done_pd(dn[0]), .done_decomp(dn[1]), .done_pa(dn[2]), .done_ntt(dn[3]), .done_dec(dn[4]),
        .start_pd(st_pd), .start_decomp(st_dc), .start_pa(st_pa), .start_ntt(st_ntt),
        .start_dec(st_dec), .op_code_pa(op), .phase(ph), .ir_base_a(base_a), .ir_base_b(base_b),
        .busy(busy), .pending(pend), .done(done_o), .error(err_o), .err_phase(errph)
    );

    decrypt_sequencer #(.N(1024), .IR_AW(12), .TIMEOUT(TO), .TW(17)) dut1024 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .done_pd(dn[0]), .done_decomp(dn[1]), .done_pa(dn[2]), .done_ntt(dn[3]), .done_dec(dn[4]),
        .start_pd(st_pd2), .start_decomp(st_dc2), .start_pa(st_pa2), .start_ntt(st_ntt2),
        .start_dec(st_dec2), .op_code_pa(op2), .phase(ph2), .ir_base_a(base_a2), .ir_base_b(base_b2),
        .busy(busy2), .pending(pend2), .done(done2), .error(err2), .err_phase(errph2)
    );

    always #5 clk = ~clk;

    logic [63:0] obs1, obs2;
    assign obs1 = {25'd0, ph, st_dec, st_ntt, st_pa, st_dc, st_pd, op, done_o, err_o, pend,
                   errph, busy, base_a, base_b};
    assign obs2 = {36'd0, ph2, busy2, base_a2, base_b2};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phases advance 1..7 then wrap to 0, driven by lookup tables
    logic [4:0] exit_mask [8] = '{5'b00000, 5'b00001, 5'b00000, 5'b00100,
                                  5'b01000, 5'b00100, 5'b00100, 5'b10000};
    logic [4:0] entry_st  [8] = '{5'b00000, 5'b00011, 5'b00001, 5'b00100,
                                  5'b01000, 5'b00100, 5'b00100, 5'b10000};
    logic [1:0] op_of     [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0};

    logic [2:0] m_ph, m_errph;
    int         m_cnt;
    bit         m_pend, m_pdok, m_dcok, e_done, e_err;
    logic [4:0] e_st;
    logic [1:0] e_op;

    function automatic void model_reset();
        m_ph = 3'd0; m_errph = 3'd0; m_cnt = 0;
        m_pend = 0; m_pdok = 0; m_dcok = 0; e_done = 0; e_err = 0;
        e_st = 5'd0; e_op = 2'd0;
    endfunction

    function automatic void model_step(input bit s, input bit a, input logic [4:0] d);
        logic [2:0] nph;
        bit leave;
        e_st = 5'd0; e_done = 0; e_err = 0;
        nph = m_ph;
        if (a) begin
            nph = 3'd0; m_pend = 0; m_pdok = 0; m_dcok = 0;
        end else if (m_ph == 3'd0) begin
            if (s || m_pend) begin
                nph = 3'd1; m_pend = 0; m_errph = 3'd0; m_pdok = 0; m_dcok = 0;
            end
        end else begin
            if (s) m_pend = 1;
            if (d[1]) m_dcok = 1;
            if (m_ph == 3'd2) begin
                if (d[0]) m_pdok = 1;
                leave = m_pdok && m_dcok;
            end else begin
                leave = |(d & exit_mask[m_ph]);
            end
            if (leave) begin
                nph = m_ph + 3'd1;
                if (nph == 3'd0) e_done = 1;
                if (nph == 3'd3) begin m_pdok = 0; m_dcok = 0; end
            end else if (m_cnt + 1 == TO) begin
                e_err = 1; m_errph = m_ph; nph = 3'd0;
            end
        end
        if (!a && nph != m_ph) e_st = entry_st[nph];
        m_cnt = (a || nph != m_ph || nph == 3'd0) ? 0 : m_cnt + 1;
        e_op  = op_of[nph];
        m_ph  = nph;
    endfunction

    function automatic logic [63:0] exp1();
        logic [10:0] ba;
        ba = (m_ph == 3'd2) ? 11'd1088 : 11'd0;
        return {25'd0, m_ph, e_st, e_op, e_done, e_err, m_pend, m_errph, (m_ph != 3'd0), ba, 11'd896};
    endfunction

    function automatic logic [63:0] exp2();
        return {36'd0, m_ph, (m_ph != 3'd0), (m_ph == 3'd2) ? 12'd2176 : 12'd0, 12'd1792};
    endfunction

    // Auto-responder: returns done_* a latency after the model's start pulse
    int         cd [5];
    logic [4:0] auto_en;
    bit         rand_lat;
    int         n_done, n_err;
    logic [2:0] last_ph;
    int         trace [$];
    logic [1:0] op_at [8];
    logic [10:0] ba_u2;
    logic [11:0] ba2_u2;

    function automatic int pick_lat();
        int r;
        if (!rand_lat) return 5;
        r = int'($urandom_range(0, 40));
        if (r == 0) return 0;
        return 1 + (r % 8);
    endfunction

    task automatic set_auto(input logic [4:0] m);
        auto_en = m;
        for (int i = 0; i < 5; i++) cd[i] = 0;
    endtask

    task automatic cycle(input bit s, input bit a, input logic [4:0] extra);
        logic [4:0] d;
        d = extra;
        for (int i = 0; i < 5; i++) begin
            if (cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0 && auto_en[i]) d[i] = 1'b1;
            end
        end
        start = s; abort = a; dn = d;
        model_step(s, a, d);
        for (int i = 0; i < 5; i++) begin
            if (a) cd[i] = 0;
            if (e_st[i]) cd[i] = pick_lat();
        end
        @(posedge clk);
        #1;
        chk("cycle_n512", obs1, exp1());
        chk("cycle_n1024", obs2, exp2());
        if (done_o) n_done++;
        if (err_o) n_err++;
        op_at[ph] = op;
        if (ph == 3'd2) begin ba_u2 = base_a; ba2_u2 = base_a2; end
        if (ph != last_ph) begin trace.push_back(int'(ph)); last_ph = ph; end
        start = 1'b0; abort = 1'b0; dn = 5'd0;
    endtask

    task automatic run_until_phase(input logic [2:0] p);
        int k;
        k = 0;
        while (m_ph != p && k < 400) begin cycle(1'b0, 1'b0, 5'd0); k++; end
        if (m_ph != p) begin
            total++; bad++;
            $display("FAIL wait_phase: phase %0d not reached, model at %0d", p, m_ph);
        end
    endtask

    typedef struct packed {
        logic       st;
        logic       ab;
        logic [4:0] di;
        logic [2:0] ph;
        logic [4:0] so;
        logic [1:0] op;
        logic       dno;
        logic       pend;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        int   k;
        logic [31:0] seq;
        logic [4:0]  stray;

        rst = 1'b1; start = 1'b0; abort = 1'b0; dn = 5'd0;
        set_auto(5'd0); rand_lat = 0; n_done = 0; n_err = 0; last_ph = 3'd0;
        ba_u2 = '0; ba2_u2 = '0;
        for (int i = 0; i < 8; i++) op_at[i] = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs1, 64'd896);
        chk("reset_state_n1024", obs2, 64'd1792);
        rst = 1'b0;

        //              st    ab    dn        ph    starts    op    done  pend
        vec[0]  = '{1'b1, 1'b0, 5'b00000, 3'd1, 5'b00011, 2'd0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 5'b00011, 3'd2, 5'b00001, 2'd0, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 5'b00001, 3'd3, 5'b00100, 2'd0, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 5'b00100, 3'd4, 5'b01000, 2'd0, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 5'b01000, 3'd5, 5'b00100, 2'd3, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 5'b00000, 3'd5, 5'b00000, 2'd3, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 5'b00100, 3'd6, 5'b00100, 2'd2, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 1'b0, 5'b00000, 3'd6, 5'b00000, 2'd2, 1'b0, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 5'b00100, 3'd7, 5'b10000, 2'd0, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 5'b10000, 3'd0, 5'b00000, 2'd0, 1'b1, 1'b1};
        vec[10] = '{1'b0, 1'b0, 5'b00000, 3'd1, 5'b00011, 2'd0, 1'b0, 1'b0};
        vec[11] = '{1'b0, 1'b0, 5'b01000, 3'd1, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b1, 5'b00001, 3'd0, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[13] = '{1'b1, 1'b1, 5'b00000, 3'd0, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[14] = '{1'b0, 1'b0, 5'b00000, 3'd0, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[15] = '{1'b1, 1'b0, 5'b00000, 3'd1, 5'b00011, 2'd0, 1'b0, 1'b0};
        vec[16] = '{1'b0, 1'b0, 5'b00001, 3'd2, 5'b00001, 2'd0, 1'b0, 1'b0};
        vec[17] = '{1'b0, 1'b0, 5'b00001, 3'd2, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[18] = '{1'b0, 1'b0, 5'b00000, 3'd2, 5'b00000, 2'd0, 1'b0, 1'b0};
        vec[19] = '{1'b0, 1'b0, 5'b00010, 3'd3, 5'b00100, 2'd0, 1'b0, 1'b0};
        vec[20] = '{1'b0, 1'b1, 5'b00000, 3'd0, 5'b00000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < NV; i++) begin
            cycle(vec[i].st, vec[i].ab, vec[i].di);
            chk($sformatf("vec%0d", i), 64'({ph, st_dec, st_ntt, st_pa, st_dc, st_pd, op, done_o, pend}),
                64'({vec[i].ph, vec[i].so, vec[i].op, vec[i].dno, vec[i].pend}));
        end

        // Nominal run, every unit answering 5 cycles after its start
        set_auto(5'b11111); n_done = 0; trace.delete(); last_ph = ph;
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd0);
        seq = 32'd0;
        foreach (trace[i]) seq = (seq << 4) | 32'(trace[i]);
        chk("nom_phase_seq", 64'(seq), 64'h1234_5670);
        chk("nom_done_count", 64'(n_done), 64'd1);
        chk("nom_ops", 64'({op_at[3], op_at[5], op_at[6]}), 64'({2'd0, 2'd3, 2'd2}));
        chk("nom_ir_base_a", 64'(ba_u2), 64'd1088);
        chk("nom_ir_base_b", 64'(base_b), 64'd896);
        chk("n1024_ir_base_a", 64'(ba2_u2), 64'd2176);
        chk("n1024_ir_base_b", 64'(base_b2), 64'd1792);

        // done_decomp held back until 20 cycles after the second done_pd
        set_auto(5'b11101);
        cycle(1'b1, 1'b0, 5'd0);
        k = 0;
        while (!(m_ph == 3'd2 && m_pdok) && k < 100) begin cycle(1'b0, 1'b0, 5'd0); k++; end
        chk("dly_reach_unpack2", 64'(ph), 64'd2);
        for (int i = 1; i < 20; i++) begin
            cycle(1'b0, 1'b0, 5'd0);
            chk("dly_hold_unpack2", 64'(ph), 64'd2);
        end
        cycle(1'b0, 1'b0, 5'b00010);
        chk("dly_start_pa", 64'({ph, st_pa, op}), 64'({3'd3, 1'b1, 2'd0}));
        set_auto(5'b11111);
        cycle(1'b0, 1'b0, 5'b00100);
        run_until_phase(3'd0);

        // Queued request: second start in INV_NTT, third (dropped) in SUB
        n_done = 0;
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd4);
        cycle(1'b1, 1'b0, 5'd0);
        chk("pend_set", 64'(pend), 64'd1);
        run_until_phase(3'd6);
        cycle(1'b1, 1'b0, 5'd0);
        chk("pend_third_dropped", 64'({ph, pend}), 64'({3'd6, 1'b1}));
        k = 0;
        while (!done_o && k < 200) begin cycle(1'b0, 1'b0, 5'd0); k++; end
        chk("pend_first_done", 64'({done_o, ph}), 64'({1'b1, 3'd0}));
        cycle(1'b0, 1'b0, 5'd0);
        chk("pend_restart", 64'({ph, st_pd, st_dc, pend}), 64'({3'd1, 1'b1, 1'b1, 1'b0}));
        run_until_phase(3'd0);
        repeat (80) cycle(1'b0, 1'b0, 5'd0);
        chk("pend_two_dones", 64'(n_done), 64'd2);

        // Watchdog: ntt never answers; a queued start must survive the error
        set_auto(5'b10111); n_done = 0; n_err = 0;
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd4);
        cycle(1'b1, 1'b0, 5'd0);
        k = 1;
        while (!err_o && k < 300) begin cycle(1'b0, 1'b0, 5'd0); k++; end
        chk("to_latency", 64'(k), 64'd100);
        chk("to_state", 64'({err_o, errph, ph, busy, pend}), 64'({1'b1, 3'd4, 3'd0, 1'b0, 1'b1}));
        cycle(1'b0, 1'b0, 5'd0);
        chk("to_queued_run", 64'({ph, errph, err_o}), 64'({3'd1, 3'd0, 1'b0}));
        chk("to_no_done", 64'(n_done), 64'd0);
        cycle(1'b0, 1'b1, 5'd0);

        // Abort in GAMMA_MULT coincident with done_pa, with a request queued
        set_auto(5'b11111);
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd3);
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd5);
        n_done = 0;
        cycle(1'b0, 1'b1, 5'b00100);
        chk("abort_gamma", 64'({ph, st_pa, pend, done_o, busy}), 64'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        repeat (10) cycle(1'b0, 1'b0, 5'd0);
        chk("abort_stays_idle", 64'({ph, n_done}), 64'({3'd0, 32'd0}));

        // Asynchronous reset in the middle of a run
        cycle(1'b1, 1'b0, 5'd0);
        run_until_phase(3'd4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", obs1, 64'd896);
        chk("async_rst_n1024", obs2, 64'd1792);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_auto(5'b11111);
        n_done = 0; n_err = 0;
        repeat (3) cycle(1'b0, 1'b0, 5'd0);
        chk("async_rst_quiet", 64'({n_done, n_err}), 64'd0);

        // Randomised traffic against the model
        rand_lat = 1;
        for (int r = 0; r < 3000; r++) begin
            stray = 5'd0;
            for (int b = 0; b < 5; b++) if ($urandom_range(0, 23) == 0) stray[b] = 1'b1;
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, stray);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
